branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Static BTFN (backward-taken / forward-not-taken) branch predictor and misprediction recovery controller for the 5-stage RISC-V pipeline.
- Sits beside the fetch stage. Issues a predicted next-PC for each fetched branch or jump.
- Tracks in-flight predictions in a small queue and compares each one with the resolved outcome in EX.
- On a misprediction, generates the PC redirect and the D/E flushes. Also keeps branch and mispredict statistics.

Parameters:
- XLEN, 32, PC and immediate width.
- DEPTH, 4, prediction queue entries (power of two, ≥2).
- CNT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch stage holds a valid instruction this cycle
- stall_f  in  1  fetch stalled; no push
- if_op  in  7  opcode of the fetched instruction
- if_pc  in  XLEN  PC of the fetched instruction
- if_immext  in  XLEN  sign-extended B/J immediate of the fetched instruction
- predict_taken  out  1  fetch should take pred_target
- pred_target  out  XLEN  if_pc + if_immext
- ex_resolve  in  1  EX holds a resolving branch/jump this cycle (single-cycle pulse per instruction)
- ex_taken  in  1  actual outcome (branch condition true, or any jump)
- ex_target  in  XLEN  actual target computed in EX
- ex_pc_plus4  in  XLEN  fall-through PC of the EX instruction
- redirect_valid  out  1  mispredict; fetch must load redirect_pc
- redirect_pc  out  XLEN  corrected PC
- flush_d  out  1  flush IF/ID register
- flush_e  out  1  flush ID/EX register
- branch_cnt  out  CNT_W  resolved branch/jump count
- mispred_cnt  out  CNT_W  mispredict count
- overflow_err  out  1  sticky: push attempted while queue full
- underflow_err  out  1  sticky: resolve with queue empty

Behaviour:
- Always decided: single clock domain; reset is asynchronous and active-low (rst_n). While rst_n=0: queue empty (rd/wr pointers and count =0), branch_cnt=0, mispred_cnt=0, overflow_err=0, underflow_err=0. Combinational outputs follow the empty-queue state.
- Prediction (combinational, zero latency):
  - op=1100011 (B-type): predict_taken = if_immext[XLEN-1].
  - op=1101111 (JAL): predict_taken = 1.
  - op=1100111 (JALR): predict_taken = 0.
  - All other opcodes: predict_taken = 0.
  - predict_taken is gated by if_valid.
  - pred_target = if_pc + if_immext, modulo 2^XLEN; wrap-around is ignored.
- Push: when if_valid & !stall_f & op ∈ {B, JAL, JALR} & !mispredict, write {predict_taken, pred_target} at the next edge.
- Pop: when ex_resolve=1, consume the head entry at the next edge.
- mispredict (combinational) = ex_resolve & (ex_taken != head.taken | (ex_taken & head.taken & ex_target != head.target)).
- When mispredict=1:
  - redirect_valid=1, flush_d=1, flush_e=1 in the same cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc_plus4.
  - At the next edge the queue is cleared entirely (younger entries are wrong-path) and any same-cycle push is dropped.
- When mispredict=0: redirect_valid=0, flush_d=0, flush_e=0, redirect_pc=0.
- Simultaneous push and pop without mispredict: count unchanged, both pointers advance (wrap modulo DEPTH).
- Full queue with push and no pop: push dropped, overflow_err set (sticky until reset). Full queue with push and pop: both performed.
- Empty queue with ex_resolve: head is treated as {taken=0, target=0}, underflow_err set (sticky), no pointer change. A mispredict is still computed from the real ex_taken.
- Counters:
  - branch_cnt +1 per ex_resolve.
  - mispred_cnt +1 per mispredict.
  - Both saturate at all-ones.
- Internal state register: RUN/RECOVER. RUN→RECOVER on mispredict. RECOVER lasts exactly one cycle, during which pushes are suppressed (the fetch stage still holds the wrong-path instruction). RECOVER→RUN unconditionally.
- rst_n asserted mid-operation aborts everything immediately; no partial flush pulse survives.

Decomposition:
- bp_pkg holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - typedef pred_entry_t {logic taken; logic [XLEN-1:0] target}
  - enum bp_state_t {RUN, RECOVER}
- One sub-module, pred_fifo: parameterised DEPTH FIFO with push, pop, clear, full, empty, count. Clear has priority over push.

Test Plan:
- Reset, then backward BEQ (if_pc=0x100, if_immext=0xFFFFFFF0) → predict_taken=1, pred_target=0x0F0. Resolve ex_taken=1, ex_target=0x0F0 → no redirect; branch_cnt=1, mispred_cnt=0.
- Forward BNE (imm=+0x20) predicted not-taken, resolved ex_taken=1, ex_target=0x120 → same cycle redirect_valid=1, redirect_pc=0x120, flush_d=flush_e=1. Next cycle queue empty, state RECOVER, push blocked. Following cycle RUN.
- JALR fetched → predict_taken=0. Resolve ex_taken=1, ex_target=0x400 → mispredict; redirect_pc=0x400, mispred_cnt increments.
- Push 4 branches with stall-free fetch and no resolves, then a 5th → 5th dropped, overflow_err=1. Resolve 4 in order; outcomes match the pushed order.
- ex_resolve with empty queue, ex_taken=0 → no redirect, underflow_err=1. Push, pop and mispredict in the same cycle → queue count 0 afterward.
- Assert rst_n=0 mid-stream with 3 queued entries and a mispredict in progress → all outputs and counters 0 immediately. First post-reset branch resolves against a fresh queue.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and opcode constants for the static BTFN branch predictor.
package bp_pkg;

    localparam int BP_XLEN = 32;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic               taken;
        logic [BP_XLEN-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bp_state_t;

    function automatic logic is_ctrl_flow(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// Small circular FIFO for in-flight predictions; clear wins over push/pop.
module pred_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full queue only fits when the head leaves this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// BTFN predictor with in-flight prediction queue, mispredict redirect/flush
// and saturating branch statistics.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int XLEN  = BP_XLEN,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic             stall_f,
    input  logic [6:0]       if_op,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_immext,
    output logic             predict_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_resolve,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic [XLEN-1:0]  ex_pc_plus4,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int CW = $clog2(DEPTH + 1);

    bp_state_t        state_q;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [XLEN:0]    fifo_rdata;
    pred_entry_t      head;
    logic             mispredict;
    logic             push_req, pop_req;

    always_comb begin
        predict_taken = 1'b0;
        if (if_valid) begin
            unique case (if_op)
                OP_BRANCH: predict_taken = if_immext[XLEN-1];
                OP_JAL:    predict_taken = 1'b1;
                default:   predict_taken = 1'b0;
            endcase
        end
    end

    assign pred_target = if_pc + if_immext;

    // An empty queue resolves as not-taken with a zero target.
    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head.taken  = fifo_rdata[XLEN];
            head.target = fifo_rdata[XLEN-1:0];
        end
    end

    assign mispredict = rst_n & ex_resolve &
                        ((ex_taken != head.taken) |
                         (ex_taken & head.taken &
                          (ex_target != head.target)));

    assign push_req = if_valid & ~stall_f & is_ctrl_flow(if_op) &
                      ~mispredict & (state_q == RUN);
    assign pop_req  = ex_resolve & ~fifo_empty;

    pred_fifo #(
        .WIDTH (XLEN + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (ex_resolve),
        .clear_i (mispredict),
        .wdata_i ({predict_taken, pred_target}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign redirect_valid = mispredict;
    assign flush_d        = mispredict;
    assign flush_e        = mispredict;
    assign redirect_pc    = !mispredict ? '0 :
                            ex_taken    ? ex_target : ex_pc_plus4;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_resolve && branch_cnt_q != '1)
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (mispredict && mispred_cnt_q != '1)
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        ovf_d = ovf_q | (push_req & fifo_full & ~pop_req);
        unf_d = unf_q | (ex_resolve & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            unique case (state_q)
                RUN:     state_q <= mispredict ? RECOVER : RUN;
                RECOVER: state_q <= RUN;
                default: state_q <= RUN;
            endcase
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
        end
    end

    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    a_count_empty: assert property (
        @(posedge clk) disable iff (!rst_n)
        (fifo_count == '0) == fifo_empty);

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed and randomized checks of branch_predict_ctrl against a
// queue-based reference model.
module tb_branch_predict_ctrl;

    localparam logic [6:0] B_OP    = 7'b1100011;
    localparam logic [6:0] JAL_OP  = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111;
    localparam logic [6:0] ALU_OP  = 7'b0010011;
    localparam int         QD      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, stall_f;
    logic [6:0]  if_op;
    logic [31:0] if_pc, if_immext;
    logic        predict_taken;
    logic [31:0] pred_target;
    logic        ex_resolve, ex_taken;
    logic [31:0] ex_target, ex_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_d, flush_e;
    logic [31:0] branch_cnt, mispred_cnt;
    logic        overflow_err, underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        t;
        logic [31:0] tg;
    } ent_t;

    ent_t        mq[$];
    bit          mrec;
    logic [31:0] mb, mm;
    bit          movf, munf;

    branch_predict_ctrl #(.XLEN(32), .DEPTH(QD), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .stall_f        (stall_f),
        .if_op          (if_op),
        .if_pc          (if_pc),
        .if_immext      (if_immext),
        .predict_taken  (predict_taken),
        .pred_target    (pred_target),
        .ex_resolve     (ex_resolve),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pc_plus4    (ex_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid    = 1'b0;
        stall_f     = 1'b0;
        if_op       = ALU_OP;
        if_pc       = '0;
        if_immext   = '0;
        ex_resolve  = 1'b0;
        ex_taken    = 1'b0;
        ex_target   = '0;
        ex_pc_plus4 = '0;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [31:0] pc,
                         input logic [31:0] imm);
        if_valid  = 1'b1;
        stall_f   = 1'b0;
        if_op     = op;
        if_pc     = pc;
        if_immext = imm;
    endtask

    task automatic resolve(input logic t, input logic [31:0] tgt,
                           input logic [31:0] pc4);
        ex_resolve  = 1'b1;
        ex_taken    = t;
        ex_target   = tgt;
        ex_pc_plus4 = pc4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #3;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_rv got %b want 0", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_rpc got %h want 0", redirect_pc); end
        n_cmp++; if ({flush_d, flush_e} !== 2'b00) begin n_err++; $display("FAIL rst_flush got %b want 00", {flush_d, flush_e}); end
        n_cmp++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
        n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_err++; $display("FAIL rst_err got %b want 00", {overflow_err, underflow_err}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_backward_beq();
        idle();
        fetch(B_OP, 32'h100, 32'hFFFF_FFF0);
        #1;
        n_cmp++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL beq_pt got %b want 1", predict_taken); end
        n_cmp++; if (pred_target !== 32'h0F0) begin n_err++; $display("FAIL beq_tgt got %h want 0f0", pred_target); end
        tick();
        idle();
        resolve(1'b1, 32'h0F0, 32'h104);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_rv got %b want 0", redirect_valid); end
        tick();
        idle();
        n_cmp++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin n_err++; $display("FAIL beq_cnt got %0d/%0d want 1/0", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_forward_mispredict();
        idle();
        fetch(B_OP, 32'h100, 32'h20);
        #1;
        n_cmp++; if (predict_taken !== 1'b0 || pred_target !== 32'h120) begin n_err++; $display("FAIL fwd_pred got %b/%h want 0/120", predict_taken, pred_target); end
        tick();
        idle();
        resolve(1'b1, 32'h120, 32'h104);
        fetch(B_OP, 32'h200, 32'hFFFF_FFF0);
        #1;
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL fwd_rv got %b want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h120) begin n_err++; $display("FAIL fwd_rpc got %h want 120", redirect_pc); end
        n_cmp++; if ({flush_d, flush_e} !== 2'b11) begin n_err++; $display("FAIL fwd_flush got %b want 11", {flush_d, flush_e}); end
        tick();
        idle();
        fetch(B_OP, 32'h300, 32'hFFFF_FFF0);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rec_rv got %b want 0", redirect_valid); end
        tick();
        idle();
        fetch(B_OP, 32'h400, 32'hFFFF_FFE0);
        tick();
        idle();
        resolve(1'b1, 32'h3E0, 32'h404);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL fresh_head_rv got %b want 0", redirect_valid); end
        tick();
        idle();
        n_cmp++; if (branch_cnt !== 32'd3 || mispred_cnt !== 32'd1) begin n_err++; $display("FAIL fwd_cnt got %0d/%0d want 3/1", branch_cnt, mispred_cnt); end
        n_cmp++; if (underflow_err !== 1'b0) begin n_err++; $display("FAIL fwd_unf got %b want 0", underflow_err); end
    endtask

    task automatic test_jalr();
        idle();
        fetch(JALR_OP, 32'h500, 32'h0);
        #1;
        n_cmp++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL jalr_pt got %b want 0", predict_taken); end
        tick();
        idle();
        resolve(1'b1, 32'h400, 32'h504);
        #1;
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin n_err++; $display("FAIL jalr_redir got %b/%h want 1/400", redirect_valid, redirect_pc); end
        tick();
        idle();
        n_cmp++; if (branch_cnt !== 32'd4 || mispred_cnt !== 32'd2) begin n_err++; $display("FAIL jalr_cnt got %0d/%0d want 4/2", branch_cnt, mispred_cnt); end
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] pc, imm;
        for (int i = 0; i < 4; i++) begin
            idle();
            pc  = 32'h1000 + 32'(i * 16);
            imm = (i % 2 == 0) ? 32'hFFFF_FFF8 : 32'h8;
            fetch(B_OP, pc, imm);
            tick();
        end
        idle();
        fetch(B_OP, 32'h2000, 32'hFFFF_FFF8);
        #1;
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_pre got %b want 0", overflow_err); end
        tick();
        idle();
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow_err); end
        for (int i = 0; i < 4; i++) begin
            idle();
            pc  = 32'h1000 + 32'(i * 16);
            imm = (i % 2 == 0) ? 32'hFFFF_FFF8 : 32'h8;
            resolve(i % 2 == 0, pc + imm, pc + 32'h4);
            #1;
            n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL ovf_order%0d got rv %b want 0", i, redirect_valid); end
            tick();
        end
        idle();
        n_cmp++; if (branch_cnt !== 32'd8 || mispred_cnt !== 32'd2) begin n_err++; $display("FAIL ovf_cnt got %0d/%0d want 8/2", branch_cnt, mispred_cnt); end
        n_cmp++; if (underflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_unf got %b want 0", underflow_err); end
    endtask

    task automatic test_underflow();
        idle();
        resolve(1'b0, 32'h0, 32'h104);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL unf_rv got %b want 0", redirect_valid); end
        tick();
        idle();
        n_cmp++; if (underflow_err !== 1'b1 || branch_cnt !== 32'd9) begin n_err++; $display("FAIL unf_set got %b/%0d want 1/9", underflow_err, branch_cnt); end
        fetch(B_OP, 32'h600, 32'hFFFF_FFFC);
        tick();
        idle();
        fetch(B_OP, 32'h700, 32'hFFFF_FFFC);
        resolve(1'b0, 32'h5FC, 32'h604);
        #1;
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h604) begin n_err++; $display("FAIL ppm_redir got %b/%h want 1/604", redirect_valid, redirect_pc); end
        tick();
        idle();
        tick();
        resolve(1'b1, 32'h6FC, 32'h704);
        #1;
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h6FC) begin n_err++; $display("FAIL ppm_empty got %b/%h want 1/6fc", redirect_valid, redirect_pc); end
        tick();
        idle();
        n_cmp++; if (branch_cnt !== 32'd11 || mispred_cnt !== 32'd4) begin n_err++; $display("FAIL ppm_cnt got %0d/%0d want 11/4", branch_cnt, mispred_cnt); end
        tick();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            idle();
            fetch(B_OP, 32'h900 + 32'(i * 16), 32'hFFFF_FFF8);
            tick();
        end
        idle();
        resolve(1'b0, 32'h0, 32'h904);
        #1;
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL mid_rv_pre got %b want 1", redirect_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({redirect_valid, flush_d, flush_e} !== 3'b000 || redirect_pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_redir got %b/%h want 000/0", {redirect_valid, flush_d, flush_e}, redirect_pc); end
        n_cmp++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
        n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_err++; $display("FAIL mid_rst_err got %b want 00", {overflow_err, underflow_err}); end
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        fetch(B_OP, 32'h800, 32'hFFFF_FFF0);
        tick();
        idle();
        resolve(1'b1, 32'h7F0, 32'h804);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_rv got %b want 0", redirect_valid); end
        tick();
        idle();
        n_cmp++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd0 || underflow_err !== 1'b0) begin n_err++; $display("FAIL post_rst_state got %0d/%0d/%b want 1/0/0", branch_cnt, mispred_cnt, underflow_err); end
    endtask

    task automatic test_random();
        ent_t        h;
        logic [31:0] mag, etg, erpc;
        logic        ept, mis, is_cf, pushreq, pop;
        int          sz;
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        mq.delete();
        mrec = 0; mb = '0; mm = '0; movf = 0; munf = 0;
        for (int i = 0; i < 800; i++) begin
            idle();
            if_valid = ($urandom_range(0, 3) != 0);
            stall_f  = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 4))
                0, 1:    if_op = B_OP;
                2:       if_op = JAL_OP;
                3:       if_op = JALR_OP;
                default: if_op = ALU_OP;
            endcase
            if_pc     = $urandom & 32'hFFFF_FFFC;
            mag       = 32'($urandom_range(1, 64)) << 2;
            if_immext = ($urandom_range(0, 1) != 0) ? -mag : mag;
            h = (mq.size() > 0) ? mq[0] : '{1'b0, 32'h0};
            ex_resolve  = ($urandom_range(0, 2) == 0);
            ex_taken    = ($urandom_range(0, 3) != 0) ? h.t : ~h.t;
            ex_target   = ($urandom_range(0, 3) != 0) ? h.tg : ($urandom & 32'hFFFF_FFFC);
            ex_pc_plus4 = $urandom;
            #1;
            is_cf = (if_op == B_OP) || (if_op == JAL_OP) || (if_op == JALR_OP);
            ept   = if_valid && ((if_op == B_OP) ? if_immext[31] : (if_op == JAL_OP));
            etg   = if_pc + if_immext;
            mis   = ex_resolve && ((ex_taken != h.t) || (ex_taken && h.t && ex_target != h.tg));
            erpc  = !mis ? 32'h0 : (ex_taken ? ex_target : ex_pc_plus4);
            n_cmp++; if (predict_taken !== ept) begin n_err++; $display("FAIL rnd%0d_pt got %b want %b", i, predict_taken, ept); end
            n_cmp++; if (pred_target !== etg) begin n_err++; $display("FAIL rnd%0d_tgt got %h want %h", i, pred_target, etg); end
            n_cmp++; if ({redirect_valid, flush_d, flush_e} !== {mis, mis, mis}) begin n_err++; $display("FAIL rnd%0d_redir got %b want %b", i, {redirect_valid, flush_d, flush_e}, {mis, mis, mis}); end
            n_cmp++; if (redirect_pc !== erpc) begin n_err++; $display("FAIL rnd%0d_rpc got %h want %h", i, redirect_pc, erpc); end
            tick();
            sz = mq.size();
            if (ex_resolve) begin
                if (mb != '1) mb++;
                if (sz == 0) munf = 1;
            end
            if (mis) begin
                if (mm != '1) mm++;
                mq.delete();
            end else begin
                pushreq = if_valid && !stall_f && is_cf && !mrec;
                pop     = ex_resolve && (sz > 0);
                if (pop) void'(mq.pop_front());
                if (pushreq) begin
                    if (sz == QD && !pop) movf = 1;
                    else mq.push_back('{ept, etg});
                end
            end
            mrec = !mrec && mis;
            n_cmp++; if (branch_cnt !== mb || mispred_cnt !== mm) begin n_err++; $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", i, branch_cnt, mispred_cnt, mb, mm); end
            n_cmp++; if ({overflow_err, underflow_err} !== {movf, munf}) begin n_err++; $display("FAIL rnd%0d_err got %b want %b", i, {overflow_err, underflow_err}, {movf, munf}); end
        end
    endtask

    initial begin
        test_reset();
        test_backward_beq();
        test_forward_mispredict();
        test_jalr();
        test_overflow();
        test_underflow();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1);
    end

endmodule
